// File: rtl/dither_inhibit_mc_if.sv
// Bus bundle for the multi-channel dither gate: per-channel enables/triggers, shared hold count,
// packed dither samples in and gated samples, hold and run flags out.
interface dither_inhibit_mc_if #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned N_B     = 16,
  parameter int unsigned NIHLD_W = 8
);
  logic [N_CH-1:0]     EN;
  logic [N_CH-1:0]     inhtrig;
  logic [NIHLD_W-1:0]  nihld;
  logic [N_CH*N_B-1:0] dith_in;
  logic [N_CH*N_B-1:0] dith_out;
  logic [N_CH-1:0]     inthld;
  logic [N_CH-1:0]     running;

  modport master (
    output EN, inhtrig, nihld, dith_in,
    input  dith_out, inthld, running
  );

  modport slave (
    input  EN, inhtrig, nihld, dith_in,
    output dith_out, inthld, running
  );
endinterface

// File: rtl/dither_inhibit_mc.sv
// Per-channel dither gate: opens/closes only on dither-cycle trigger edges and holds the
// dither-lock integrator until nihld+1 full dither cycles have been counted.
module dither_inhibit_mc #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned N_B     = 16,
  parameter int unsigned NIHLD_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  dither_inhibit_mc_if.slave    bus
);
  localparam int unsigned CNT_W = NIHLD_W + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETTLE    = 2'd1,
    LOCK      = 2'd2,
    WAIT_STOP = 2'd3
  } state_e;

  state_e              state_q [N_CH];
  state_e              state_d [N_CH];
  logic [CNT_W-1:0]    cnt_q   [N_CH];
  logic [CNT_W-1:0]    cnt_d   [N_CH];
  logic [N_CH-1:0]     trig_q;
  logic [N_CH-1:0]     inthld_q;
  logic [N_CH-1:0]     running_q;
  logic [N_CH*N_B-1:0] dith_d1_q;
  logic [N_CH*N_B-1:0] dith_out_q;
  logic [N_CH-1:0]     edge_c;
  logic [CNT_W-1:0]    tgt_c;

  assign edge_c = bus.inhtrig & ~trig_q;
  assign tgt_c  = CNT_W'(bus.nihld) + CNT_W'(1);

  function automatic state_e next_state(state_e st, logic en, logic ed,
                                        logic [CNT_W-1:0] cnt, logic [CNT_W-1:0] tgt);
    next_state = st;
    case (st)
      IDLE:      if (en && ed) next_state = SETTLE;
      SETTLE: begin
        if (!en)                                       next_state = WAIT_STOP;
        else if (ed ? (cnt + CNT_W'(1) >= tgt) : (cnt >= tgt)) next_state = LOCK;
      end
      LOCK:      if (!en) next_state = WAIT_STOP;
      WAIT_STOP: begin
        if (en)      next_state = SETTLE;
        else if (ed) next_state = IDLE;
      end
      default:   next_state = IDLE;
    endcase
  endfunction

  // Cycle count saturates at the target so a long settle never wraps.
  function automatic logic [CNT_W-1:0] next_cnt(state_e st, logic en, logic ed,
                                                logic [CNT_W-1:0] cnt, logic [CNT_W-1:0] tgt);
    next_cnt = cnt;
    case (st)
      IDLE:      if (en && ed) next_cnt = CNT_W'(1);
      SETTLE: begin
        if (!en)     next_cnt = '0;
        else if (ed) next_cnt = (cnt + CNT_W'(1) > tgt) ? tgt : cnt + CNT_W'(1);
      end
      LOCK:      if (!en) next_cnt = '0;
      WAIT_STOP: if (en) next_cnt = ed ? CNT_W'(1) : '0;
      default:   next_cnt = '0;
    endcase
  endfunction

  always_comb begin
    for (int c = 0; c < int'(N_CH); c++) begin
      state_d[c] = next_state(state_q[c], bus.EN[c], edge_c[c], cnt_q[c], tgt_c);
      cnt_d[c]   = next_cnt(state_q[c], bus.EN[c], edge_c[c], cnt_q[c], tgt_c);
    end
  end

  // Outputs are registered from the state being entered so the gate flips on the edge posedge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q     <= '1;
      inthld_q   <= '1;
      running_q  <= '0;
      dith_d1_q  <= '0;
      dith_out_q <= '0;
      for (int c = 0; c < int'(N_CH); c++) begin
        state_q[c] <= IDLE;
        cnt_q[c]   <= '0;
      end
    end else begin
      trig_q    <= bus.inhtrig;
      dith_d1_q <= bus.dith_in;
      for (int c = 0; c < int'(N_CH); c++) begin
        state_q[c]   <= state_d[c];
        cnt_q[c]     <= cnt_d[c];
        inthld_q[c]  <= (state_d[c] != LOCK);
        running_q[c] <= (state_d[c] != IDLE);
        dith_out_q[c*N_B +: N_B] <= (state_d[c] != IDLE) ? dith_d1_q[c*N_B +: N_B] : '0;
      end
    end
  end

  assign bus.dith_out = dith_out_q;
  assign bus.inthld   = inthld_q;
  assign bus.running  = running_q;
endmodule
